// File: rtl/pipe_stage_reg_pkg.sv
// Shared defaults and handshake FSM encoding for the MIPS32 inter-stage pipeline register.
// Used by every file of pipe_stage_reg; the optional skid buffer is selected by PIPE_SKID_EN.
package pipe_pkg;
  localparam int DEF_CTL_W    = 2;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_DATA = 2;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// One side of a pipeline-stage link: beat payload plus valid/ready handshake.
// A beat transfers on a rising edge where valid and ready are both 1; master holds valid and payload until then.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTL_W    = DEF_CTL_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = DEF_NUM_DATA,
  parameter int ADDR_W   = DEF_ADDR_W
) ();
  logic                       valid;
  logic                       ready;
  logic [CTL_W-1:0]           ctl;
  logic [NUM_DATA*DATA_W-1:0] data;
  logic [ADDR_W-1:0]          addr;

  modport master (output valid, output ctl, output data, output addr, input ready);
  modport slave  (input valid, input ctl, input data, input addr, output ready);
endinterface

// File: rtl/pipe_stage_reg_payload.sv
// Enable-loaded payload register {ctl, data, addr} with synchronous clear.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready back-pressure, flush and bubble gating.
// Define PIPE_SKID_EN for the 2-entry skid version with a fully registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTL_W    = DEF_CTL_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = DEF_NUM_DATA,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master down,
  output state_t           state
);
  localparam int PAY_W = CTL_W + NUM_DATA * DATA_W + ADDR_W;

  state_t           state_q, state_d;
  logic [PAY_W-1:0] in_pay, main_d, main_q;
  logic             main_load, in_ready, out_valid, in_fire, out_fire;
`ifdef PIPE_SKID_EN
  logic [PAY_W-1:0] skid_q;
  logic             skid_load;
`endif

  assign in_pay    = {up.ctl, up.data, up.addr};
  assign out_valid = (state_q != ST_EMPTY);
`ifdef PIPE_SKID_EN
  assign in_ready  = (state_q != ST_SKID);
`else
  assign in_ready  = down.ready | ~out_valid;
`endif
  assign in_fire   = up.valid & in_ready;
  assign out_fire  = out_valid & down.ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_pay;
`ifdef PIPE_SKID_EN
    skid_load = 1'b0;
`endif
    // Flush leaves the payload registers untouched; only validity is dropped.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && down.ready) begin
            main_load = 1'b1;
`ifdef PIPE_SKID_EN
          end else if (in_fire) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
`ifdef PIPE_SKID_EN
          if (down.ready) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
            main_d    = skid_q;
          end
`else
          state_d = ST_EMPTY;
`endif
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_payload_reg #(.W(PAY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

`ifdef PIPE_SKID_EN
  pipe_payload_reg #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_pay),
    .q     (skid_q)
  );
`endif

  // Control is zeroed on bubbles so an invalid slot can never write the register file.
  assign down.valid = out_valid;
  assign down.ctl   = out_valid ? main_q[PAY_W-1 -: CTL_W] : '0;
  assign down.data  = main_q[ADDR_W +: NUM_DATA * DATA_W];
  assign down.addr  = main_q[ADDR_W-1:0];
  assign up.ready   = in_ready;
  assign state      = state_q;
endmodule
